ram_mem_sync: RTL and testbench
===============================

RAM_MEM_SYNC -- requirements
Module: ram_mem_sync

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: address width; depth is 2**ADDR_WIDTH words.
REQ-002 Parameter WIDTH, default 8: data word width; SHALL be a multiple of 8.
REQ-003 Parameter NBYTES, default WIDTH/8: number of byte lanes.
REQ-004 CLK  input  1: single clock; all state changes on its rising edge.
REQ-005 RST  input  1: reset, asynchronous, active-high.
REQ-006 CE  input  1: write enable.
REQ-007 BE  input  NBYTES: byte-lane write mask; bit i covers DATA_IN[8i+7:8i].
REQ-008 WADDR  input  ADDR_WIDTH: write address.
REQ-009 DATA_IN  input  WIDTH: write data.
REQ-010 RE  input  1: read request.
REQ-011 RADDR  input  ADDR_WIDTH: read address.
REQ-012 CLR  input  1: single-cycle pulse that restarts the memory-clear sequence.
REQ-013 DATA_OUT  output  WIDTH: registered read data.
REQ-014 DATA_VALID  output  1: DATA_OUT holds the result of a read accepted on the previous edge.
REQ-015 BUSY  output  1: clear sequence in progress; requests are ignored.

Function
REQ-016 The block SHALL have two states: CLEAR and READY.
REQ-017 In CLEAR, the block SHALL write all-zero data to the word at clear counter CNT each cycle, then increment CNT.
REQ-018 When CNT equals 2**ADDR_WIDTH-1 in CLEAR, the block SHALL write that word, set CNT to 0 and move to READY on the same edge.
REQ-019 The clear sequence SHALL take exactly 2**ADDR_WIDTH cycles; BUSY SHALL be 1 only in CLEAR.
REQ-020 In READY, an asserted CLR SHALL set CNT to 0 and move to CLEAR; CLR asserted in CLEAR SHALL restart CNT at 0.
REQ-021 In CLEAR, CE and RE SHALL be ignored; DATA_VALID SHALL be 0 and DATA_OUT SHALL hold its value.
REQ-022 In READY with CE=1, each lane i with BE[i]=1 SHALL be written at WADDR; lanes with BE[i]=0 SHALL be unchanged; CE=1 with BE=0 SHALL write nothing.
REQ-023 In READY with RE=1, DATA_OUT SHALL present mem[RADDR] after one edge (latency 1), with DATA_VALID=1 in that cycle.
REQ-024 If RE=0, DATA_VALID SHALL be 0 on the next cycle and DATA_OUT SHALL hold its last value.
REQ-025 On a same-edge read and write with RADDR==WADDR, reads SHALL be write-first: enabled lanes return DATA_IN and disabled lanes return stored data.
REQ-026 On a same-edge read and write with RADDR!=WADDR, the read SHALL return the stored pre-write word.
REQ-027 Back-to-back reads SHALL be accepted every cycle with no bubbles.
REQ-028 CLR and CE asserted on the same READY edge: CLR SHALL win and the write SHALL be dropped.

Reset
REQ-029 RST=1 SHALL immediately force DATA_OUT=0, DATA_VALID=0 and CNT=0, and put the state in CLEAR (BUSY=1).
REQ-030 Memory array contents SHALL NOT be reset asynchronously; zeroing happens only through the clear sequence.
REQ-031 RST asserted during a clear SHALL restart the sequence from address 0 after release.

Configuration
REQ-032 Macro RAM_MEM_SYNC_CLEAR_EN defined: the CLEAR state, CNT and CLR behaviour exist as specified above.
REQ-033 Macro undefined: reset enters READY, BUSY is tied 0, CLR is ignored, and memory contents after reset are undefined; all other behaviour is unchanged.

Verification (ADDR_WIDTH=4, WIDTH=16, macro defined unless stated)
REQ-034 Release RST -> BUSY=1 for exactly 16 cycles; a subsequent read of every address returns 0x0000 with DATA_VALID=1 one cycle after each RE.
REQ-035 Write 0xABCD to addr 3 with BE=2'b11, then BE=2'b01 with data 0x1234 -> read of addr 3 returns 0xAB34.
REQ-036 Same edge: CE, WADDR=5, BE=2'b10, DATA_IN=0x5600; RE, RADDR=5 (stored 0x0011) -> DATA_OUT=0x5611; with RADDR=6 instead -> stored value of addr 6.
REQ-037 Pulse CLR in READY with CE=1 to addr 7 -> write dropped, BUSY=1 for 16 cycles, RE during BUSY gives DATA_VALID=0, and addr 7 then reads 0x0000.
REQ-038 Assert RST at clear cycle 9 -> outputs are 0 immediately and, after release, BUSY lasts a full 16 cycles.
REQ-039 Macro undefined: release RST -> BUSY=0 at once; write then read of addr 15 with 0xBEEF returns 0xBEEF; a CLR pulse has no effect.

Source files
------------

// File: rtl/ram_mem_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_mem_sync_if
//  Brief    : Request/response bundle for the ram_mem_sync byte-lane RAM.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_mem_sync_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8,
    parameter int NBYTES     = WIDTH / 8
);
    logic                  CE;
    logic [NBYTES-1:0]     BE;
    logic [ADDR_WIDTH-1:0] WADDR;
    logic [WIDTH-1:0]      DATA_IN;
    logic                  RE;
    logic [ADDR_WIDTH-1:0] RADDR;
    logic                  CLR;
    logic [WIDTH-1:0]      DATA_OUT;
    logic                  DATA_VALID;
    logic                  BUSY;

    modport master (
        output CE, BE, WADDR, DATA_IN, RE, RADDR, CLR,
        input  DATA_OUT, DATA_VALID, BUSY
    );

    modport slave (
        input  CE, BE, WADDR, DATA_IN, RE, RADDR, CLR,
        output DATA_OUT, DATA_VALID, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/ram_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module   : ram_mem_sync
//  Brief    : Single-clock RAM with byte-lane writes, write-first registered
//             read and optional hardware clear (macro RAM_MEM_SYNC_CLEAR_EN).
//  Revision : 1.0  initial release
// ============================================================================
module ram_mem_sync #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 8,
    parameter int NBYTES     = WIDTH / 8
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    ram_mem_sync_if.slave bus
);

    localparam int                    c_depth     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

    if ((WIDTH % 8 != 0) || (NBYTES != WIDTH / 8)) begin : g_bad_width
        $error("ram_mem_sync: WIDTH must be a multiple of 8 and NBYTES = WIDTH/8");
    end

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [WIDTH-1:0]      r_data_out;
    logic                  r_data_valid;

    logic                  w_ready;
    logic                  w_clr;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [WIDTH-1:0]      w_mem_data;
    logic [NBYTES-1:0]     w_mem_be;
    logic [WIDTH-1:0]      w_stored;
    logic [WIDTH-1:0]      w_rd_data;

`ifdef RAM_MEM_SYNC_CLEAR_EN
    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (bus.CLR) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_last_addr) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_READY;
                end else begin
                    w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                end
            end
            S_READY: begin
                if (bus.CLR) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_CLEAR;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_CLEAR;
            end
        endcase
    end

    assign w_ready = (r_state == S_READY);
    assign w_clr   = bus.CLR;

    // While clearing, the write port is borrowed to zero one full word per cycle.
    assign w_mem_addr = w_ready ? bus.WADDR   : r_cnt;
    assign w_mem_data = w_ready ? bus.DATA_IN : '0;
    assign w_mem_be   = w_ready ? (w_wr_en ? bus.BE : '0) : '1;
`else
    logic w_unused_clr;

    assign w_unused_clr = bus.CLR;
    assign w_ready      = 1'b1;
    assign w_clr        = 1'b0;
    assign w_mem_addr   = bus.WADDR;
    assign w_mem_data   = bus.DATA_IN;
    assign w_mem_be     = w_wr_en ? bus.BE : '0;
`endif

    // A clear request on a READY edge takes priority over a coincident write.
    assign w_wr_en = w_ready & bus.CE & ~w_clr;
    assign w_rd_en = w_ready & bus.RE;

    // Array has no reset; its contents only change through the write port.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (w_mem_be[i]) begin
                r_mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
            end
        end
    end

    assign w_stored = r_mem[bus.RADDR];

    // Write-first bypass, resolved independently for each byte lane.
    for (genvar g = 0; g < NBYTES; g++) begin : g_lane
        assign w_rd_data[8*g +: 8] =
            (w_wr_en && bus.BE[g] && (bus.WADDR == bus.RADDR)) ?
            bus.DATA_IN[8*g +: 8] : w_stored[8*g +: 8];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_rd_en;
            if (w_rd_en) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign bus.DATA_OUT   = r_data_out;
    assign bus.DATA_VALID = r_data_valid;
    assign bus.BUSY       = ~w_ready;

endmodule
`default_nettype wire

// File: tb/tb_ram_mem_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_mem_sync
//  Brief    : Scoreboard bench for ram_mem_sync (ADDR_WIDTH=4, WIDTH=16).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_mem_sync;

    localparam int AW    = 4;
    localparam int W     = 16;
    localparam int NB    = 2;
    localparam int DEPTH = 16;
`ifdef RAM_MEM_SYNC_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    ram_mem_sync_if #(.ADDR_WIDTH(AW), .WIDTH(W), .NBYTES(NB)) bus ();

    ram_mem_sync #(.ADDR_WIDTH(AW), .WIDTH(W), .NBYTES(NB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int             n_checks = 0;
    int             n_fail   = 0;
    logic [W-1:0]   m_mem [DEPTH];
    logic           m_busy    = 1'b0;
    logic [AW-1:0]  m_cnt     = '0;
    logic           exp_valid = 1'b0;
    logic           mon_en    = 1'b0;
    logic [W-1:0]   sb_q [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Applies one cycle of stimulus, then advances the reference model.
    task automatic drive(input logic ce, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                         input logic [W-1:0] din, input logic re, input logic [AW-1:0] ra,
                         input logic clr);
        logic         wr;
        logic [W-1:0] rd;
        bus.CE = ce; bus.BE = be; bus.WADDR = wa; bus.DATA_IN = din;
        bus.RE = re; bus.RADDR = ra; bus.CLR = clr;
        @(posedge CLK);
        #1;
        if (m_busy) begin
            m_mem[m_cnt] = '0;
            exp_valid    = 1'b0;
            if (clr) m_cnt = '0;
            else if (m_cnt == AW'(DEPTH - 1)) begin
                m_cnt  = '0;
                m_busy = 1'b0;
            end else m_cnt = m_cnt + AW'(1);
        end else begin
            wr = ce && !(CLEAR_EN && clr);
            if (re) begin
                rd = m_mem[ra];
                for (int i = 0; i < NB; i++)
                    if (wr && be[i] && (wa == ra)) rd[8*i +: 8] = din[8*i +: 8];
                sb_q.push_back(rd);
            end
            exp_valid = re;
            if (wr)
                for (int i = 0; i < NB; i++)
                    if (be[i]) m_mem[wa][8*i +: 8] = din[8*i +: 8];
            if (CLEAR_EN && clr) begin
                m_busy = 1'b1;
                m_cnt  = '0;
            end
        end
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic apply_reset(input int hold);
        bus.CE = 1'b0; bus.BE = '0; bus.WADDR = '0; bus.DATA_IN = '0;
        bus.RE = 1'b0; bus.RADDR = '0; bus.CLR = 1'b0;
        RST = 1'b1;
        #1;
        check_eq("rst_dout",  bus.DATA_OUT,   0);
        check_eq("rst_valid", bus.DATA_VALID, 0);
        check_eq("rst_busy",  bus.BUSY,       CLEAR_EN);
        m_busy    = CLEAR_EN;
        m_cnt     = '0;
        exp_valid = 1'b0;
        sb_q.delete();
        mon_en    = 1'b1;
        repeat (hold) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic busy_len(input string tag, input logic re, input logic [AW-1:0] ra);
        int n = 0;
        while (bus.BUSY === 1'b1 && n < 40) begin
            drive(1'b0, '0, '0, '0, re, ra, 1'b0);
            n++;
        end
        check_eq(tag, n, CLEAR_EN ? 16 : 0);
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            check_eq("valid", bus.DATA_VALID, exp_valid);
            check_eq("busy",  bus.BUSY,       m_busy);
            if (exp_valid && sb_q.size() > 0)
                check_eq("rdata", bus.DATA_OUT, sb_q.pop_front());
        end
    end

    initial begin
        bus.CE = 1'b0; bus.BE = '0; bus.WADDR = '0; bus.DATA_IN = '0;
        bus.RE = 1'b0; bus.RADDR = '0; bus.CLR = 1'b0;
        @(posedge CLK);
        #1;
        apply_reset(2);
        busy_len("busy_after_rst", 1'b0, '0);

        // Without hardware clear the array starts undefined, so zero it by hand.
        if (!CLEAR_EN)
            for (int a = 0; a < DEPTH; a++) drive(1'b1, 2'b11, AW'(a), '0, 1'b0, '0, 1'b0);
        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
        idle();

        drive(1'b1, 2'b11, 4'd3, 16'hABCD, 1'b0, '0, 1'b0);
        drive(1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        check_eq("be_merge", bus.DATA_OUT, 16'hAB34);

        drive(1'b1, 2'b11, 4'd15, 16'hBEEF, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd15, 1'b0);
        check_eq("addr15", bus.DATA_OUT, 16'hBEEF);

        drive(1'b1, 2'b11, 4'd5, 16'h0011, 1'b0, '0, 1'b0);
        drive(1'b1, 2'b11, 4'd6, 16'h7777, 1'b0, '0, 1'b0);
        drive(1'b1, 2'b10, 4'd5, 16'h5600, 1'b1, 4'd5, 1'b0);
        check_eq("wr_first_same", bus.DATA_OUT, 16'h5611);
        drive(1'b1, 2'b10, 4'd5, 16'h5600, 1'b1, 4'd6, 1'b0);
        check_eq("wr_first_other", bus.DATA_OUT, 16'h7777);

        for (int k = 0; k < 60; k++)
            drive(1'($urandom_range(0, 1)), NB'($urandom_range(0, 3)), AW'($urandom_range(0, 15)),
                  W'($urandom), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 1'b0);

        drive(1'b1, 2'b11, 4'd7, 16'h9999, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        drive(1'b1, 2'b11, 4'd7, 16'h4242, 1'b0, '0, 1'b1);
        busy_len("clr_busy", 1'b1, 4'd7);
        check_eq("hold_dout", bus.DATA_OUT, 16'h9999);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd7, 1'b0);
        check_eq("clr_addr7", bus.DATA_OUT, CLEAR_EN ? 16'h0000 : 16'h4242);

        drive(1'b1, 2'b11, 4'd2, 16'h00F0, 1'b0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
        drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        repeat (9) idle();
        apply_reset(2);
        busy_len("busy_after_rst2", 1'b0, '0);
        drive(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
        idle();
        check_eq("sb_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
